// File: rtl/wb_conmax_cfg_loader_pkg.sv
// Shared connection-matrix definitions: loader state encoding, failure codes and
// register-file address field positions.
package wb_conmax_cfg_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4,
      ST_FAIL = 3'd5
   } cfg_state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_ERR      = 2'b01;
   localparam logic [1:0] FC_RTY      = 2'b10;
   localparam logic [1:0] FC_MISMATCH = 2'b11;

   // Register-file select sits at [aw-5:aw-8]; the conf index at [5:2].
   localparam int RF_SEL_HI_OFS = 5;
   localparam int RF_SEL_W      = 4;
   localparam int RF_IDX_LSB    = 2;
   localparam int RF_IDX_W      = 4;

   function automatic logic [15:0] slot_of(input logic [255:0] v, input logic [3:0] i);
      return v[{i, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/wb_conmax_cfg_loader.sv
// Wishbone initiator that writes the 16 conf registers of the connection matrix
// from a parameter table and optionally reads them back to confirm.
module wb_conmax_cfg_loader
   import wb_conmax_cfg_loader_pkg::*;
#(
   parameter logic [3:0]   rf_addr  = 4'hf,
   parameter int           dw       = 32,
   parameter int           aw       = 32,
   parameter int           sw       = dw / 8,
   parameter logic [255:0] init_val = 256'h0,
   parameter int           verify   = 1,
   parameter int           max_rty  = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [dw-1:0] wb_data_i,
   output logic [dw-1:0] wb_data_o,
   output logic [aw-1:0] wb_addr_o,
   output logic [sw-1:0] wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          fail_o,
   output logic [1:0]    fail_code_o,
   output logic [3:0]    fail_idx_o,
   output cfg_state_e    dbg_state_o
);

   localparam int RW = (max_rty < 1) ? 1 : $clog2(max_rty + 1);

   cfg_state_e    state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [RW-1:0] rty_q, rty_d;
   logic          rd_pass_q, rd_pass_d;
   logic          adv_q, adv_d;
   logic [1:0]    code_q, code_d;
   logic [3:0]    fidx_q, fidx_d;

   logic [dw-1:0] exp_data;
   logic [aw-1:0] acc_addr;

   always_comb begin
      exp_data = '0;
      exp_data[15:0] = slot_of(init_val, idx_q);
      acc_addr = '0;
      acc_addr[aw-RF_SEL_HI_OFS -: RF_SEL_W] = rf_addr;
      acc_addr[RF_IDX_LSB +: RF_IDX_W] = idx_q;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rty_d     = rty_q;
      rd_pass_d = rd_pass_q;
      adv_d     = adv_q;
      code_d    = code_q;
      fidx_d    = fidx_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_i) begin
               state_d   = ST_WR;
               idx_d     = '0;
               rty_d     = '0;
               rd_pass_d = 1'b0;
               adv_d     = 1'b0;
               code_d    = FC_NONE;
               fidx_d    = '0;
            end
         end
         ST_WR, ST_RD: begin
            if (wb_err_i) begin
               state_d = ST_FAIL;
               code_d  = FC_ERR;
               fidx_d  = idx_q;
            end else if (wb_rty_i) begin
               if (rty_q == RW'(max_rty)) begin
                  state_d = ST_FAIL;
                  code_d  = FC_RTY;
                  fidx_d  = idx_q;
               end else begin
                  rty_d   = rty_q + RW'(1);
                  adv_d   = 1'b0;
                  state_d = ST_GAP;
               end
            end else if (wb_ack_i) begin
               if (state_q == ST_RD && wb_data_i != exp_data) begin
                  state_d = ST_FAIL;
                  code_d  = FC_MISMATCH;
                  fidx_d  = idx_q;
               end else begin
                  adv_d   = 1'b1;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            // A non-advancing GAP reissues the same access after a retry.
            state_d = rd_pass_q ? ST_RD : ST_WR;
            if (adv_q) begin
               adv_d = 1'b0;
               rty_d = '0;
               if (idx_q == 4'hf) begin
                  idx_d = '0;
                  if (!rd_pass_q && verify != 0) begin
                     rd_pass_d = 1'b1;
                     state_d   = ST_RD;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         rty_q     <= '0;
         rd_pass_q <= 1'b0;
         adv_q     <= 1'b0;
         code_q    <= FC_NONE;
         fidx_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rty_q     <= rty_d;
         rd_pass_q <= rd_pass_d;
         adv_q     <= adv_d;
         code_q    <= code_d;
         fidx_q    <= fidx_d;
      end
   end

   // Bus outputs decode only registered state, so reset clears them at once.
   always_comb begin
      wb_cyc_o  = 1'b0;
      wb_stb_o  = 1'b0;
      wb_we_o   = 1'b0;
      wb_sel_o  = '0;
      wb_addr_o = '0;
      wb_data_o = '0;
      case (state_q)
         ST_WR: begin
            wb_cyc_o  = 1'b1;
            wb_stb_o  = 1'b1;
            wb_we_o   = 1'b1;
            wb_sel_o  = '1;
            wb_addr_o = acc_addr;
            wb_data_o = exp_data;
         end
         ST_RD: begin
            wb_cyc_o  = 1'b1;
            wb_stb_o  = 1'b1;
            wb_sel_o  = '1;
            wb_addr_o = acc_addr;
         end
         default: ;
      endcase
   end

   assign busy_o      = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_GAP);
   assign done_o      = (state_q == ST_DONE);
   assign fail_o      = (state_q == ST_FAIL);
   assign fail_code_o = code_q;
   assign fail_idx_o  = fidx_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/wb_conmax_cfg_loader.md
# wb_conmax_cfg_loader

Wishbone initiator that programs the interconnect's 16-entry configuration register file after reset or on software request. On `start_i` it writes `init_val` slots 0..15 into conf0..conf15, then optionally reads all 16 back and compares. It sits on a master port of the connection matrix, on the opposite end of the register-file responder. It reports completion or the first failure with its cause and slot index.

## Interface
- `rf_addr`, 4'hf: register-file select value driven on `wb_addr_o[aw-5:aw-8]`.
- `dw`, 32: data bus width.
- `aw`, 32: address bus width.
- `sw`, dw/8: number of select lines.
- `init_val`, 256'h0: 16 slots of 16 bits; slot i is `init_val[16*i+15:16*i]`.
- `verify`, 1: if 1, run a read-back pass after the write pass.
- `max_rty`, 3: number of retries allowed per access before failure.

Ports:
- `clk_i`, in, 1: clock; the block uses one clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `start_i`, in, 1: start pulse. Ignored while `busy_o` is high.
- `wb_data_i`, in, dw: read data.
- `wb_data_o`, out, dw: write data.
- `wb_addr_o`, out, aw: address.
- `wb_sel_o`, out, sw: byte selects.
- `wb_we_o`, out, 1: write enable.
- `wb_cyc_o`, out, 1: cycle.
- `wb_stb_o`, out, 1: strobe.
- `wb_ack_i`, in, 1: acknowledge.
- `wb_err_i`, in, 1: error.
- `wb_rty_i`, in, 1: retry.
- `busy_o`, out, 1: sequence in progress.
- `done_o`, out, 1: sequence completed cleanly. Held until the next start.
- `fail_o`, out, 1: sequence aborted. Held until the next start.
- `fail_code_o`, out, 2: failure cause. 00 none, 01 err, 10 retries exhausted, 11 read-back mismatch.
- `fail_idx_o`, out, 4: slot index of the failing access.

## Operation
- States: IDLE, WR, RD, GAP, DONE, FAIL.
- IDLE/DONE/FAIL + `start_i`:
  - Go to WR with idx=0 and rty_cnt=0.
  - Clear done, fail, code and fail_idx.
- Address for every access: bits [aw-1:aw-4]=0, [aw-5:aw-8]=`rf_addr`, [5:2]=idx, all other bits 0.
- Bus outputs in WR:
  - `cyc`=`stb`=`we`=1, `sel`=all ones.
  - `data_o`={(dw-16) zeros, slot[idx]}.
- Bus outputs in RD: `cyc`=`stb`=1, `we`=0, `data_o`=0.
- Bus outputs in all other states: `cyc`=`stb`=`we`=0. `addr`, `sel` and `data` are 0 in IDLE/DONE/FAIL.
- Response priority when sampled in WR/RD is err > rty > ack:
  - err: go to FAIL, code 01.
  - rty: if rty_cnt==`max_rty`, go to FAIL with code 10. Otherwise increment rty_cnt, go to GAP, then reissue the same access.
  - ack in WR: go to GAP. The pass advances after GAP: idx+1; after idx 15, switch to the RD pass (if `verify`) or DONE.
  - ack in RD: compare `wb_data_i` against {(dw-16) zeros, slot[idx]}. A mismatch goes to FAIL with code 11. A match goes to GAP and advances; after idx 15, go to DONE.
- On each advance: rty_cnt clears and idx wraps 15→0 at the pass switch.
- GAP lasts exactly one cycle with `cyc` low. This lets the responder's ack toggle return low, so no ack is double-counted.
- No response: the block stays in WR/RD indefinitely. The block has no timeout; bus timeout is the arbiter's job.
- `fail_idx_o` latches idx on entry to FAIL.

## Timing
- Reset values:
  - All bus outputs 0.
  - `busy_o`=`done_o`=`fail_o`=0, `fail_code_o`=00, `fail_idx_o`=0.
  - State IDLE.
  - Reset mid-transfer drops `cyc`/`stb` immediately (asynchronously).
- Registered outputs. `cyc` rises the cycle after `start_i` is sampled.
- A single-cycle-ack responder (ack one cycle after `stb`) costs 3 cycles per access: 2 with `cyc` high plus 1 GAP.
- Full sequence from the start edge to `done_o`:
  - Write pass only: 48 cycles.
  - With `verify`: 96 cycles.
- `busy_o` is high from the cycle after start through the last GAP. It equals state ∉ {IDLE, DONE, FAIL}.
- `start_i` in the same cycle as a terminal response is ignored.

## Structure
- Shared package (conmax-wide) holds:
  - State encoding.
  - fail_code constants.
  - The rf address field positions ([aw-5:aw-8], [5:2]).
- The address/data builder (idx, pass → `addr`/`data_o`/expected) is combinational and stays inline. No sub-module is needed; one FSM plus the idx and rty counters.

## Test plan
- Default params, `init_val` slot i = 16'h1000+i, loader connected to the register-file responder, start pulse → conf0..conf15 = 16'h1000..16'h100F, `done_o`=1 at cycle 96, `fail_o`=0.
- `verify`=0 → only 16 write cycles issued, `done_o` at cycle 48, no read ever seen (`we` never low with `cyc` high).
- Responder model asserts `rty` twice on slot 5 write, `max_rty`=3 → slot 5 written after 2 retries, sequence completes with 6 extra cycles. `rty` 4 times → `fail_o`=1, code 10, idx 5.
- `err` on slot 9 read → FAIL, code 01, `fail_idx_o`=9, `cyc` low the next cycle, `busy_o`=0.
- Model corrupts read data of slot 3 (returns 16'hDEAD) → FAIL, code 11, idx 3. A fresh start then clears the flags and the sequence passes.
- Assert `rst_i` while `cyc` is high mid-write → all outputs 0 immediately. `start_i` after release restarts at idx 0.
